mem_sram_ctrl: RTL and testbench
================================

Name: mem_sram_ctrl

Overview:
Parametrised memory-stage controller for the 5-stage MIPS pipeline. It replaces the single-cycle data memory with an access to an external multi-cycle SRAM whose data bus may be narrower than the CPU word. It sits between the EXE/MEM pipeline register and the MEM/WB register. It asserts freeze to hold the whole pipeline until the access completes.

Parameters:
DATA_W, 32, CPU word width; must be a multiple of SRAM_DQ_W.
SRAM_DQ_W, 16, SRAM data bus width. BEATS = DATA_W/SRAM_DQ_W.
SRAM_ADDR_W, 18, SRAM word-address width.
WAIT_CYCLES, 2, clocks per SRAM beat; must be >=1.
BASE_ADDR, 1024, CPU byte address mapped to SRAM word 0.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-low
mem_r_en  in  1  load request from EXE/MEM register
mem_w_en  in  1  store request from EXE/MEM register
address  in  DATA_W  ALU result, byte address
write_data  in  DATA_W  store data
read_data  out  DATA_W  load result, to MEM/WB register
ready  out  1  one-cycle completion pulse
freeze  out  1  pipeline hold; all pipeline registers keep their contents while high
sram_addr  out  SRAM_ADDR_W  SRAM word address
sram_dq_in  in  SRAM_DQ_W  SRAM read data
sram_dq_out  out  SRAM_DQ_W  SRAM write data
sram_dq_oe  out  1  drive enable for the external tristate
sram_ce_n  out  1  chip enable, active-low
sram_oe_n  out  1  output enable, active-low
sram_we_n  out  1  write enable, active-low

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE; read_data=0; ready=0; freeze=0.
  - sram_ce_n=1, sram_oe_n=1, sram_we_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_out=0.
  - Reset mid-access aborts the access. The SRAM is released at the next edge and no ready pulse is produced.
- Address mapping: word = (address - BASE_ADDR) >> log2(DATA_W/8). The subtraction is unsigned and wraps; there is no range error. For beat b, sram_addr = (word*BEATS + b) truncated to SRAM_ADDR_W.
- Beat ordering is little-endian: beat 0 carries bits [SRAM_DQ_W-1:0].
- FSM states: IDLE, ACCESS, DONE.
  - IDLE: when mem_r_en or mem_w_en is high, latch address, write_data and the op, clear beat and cycle counters, and go to ACCESS. If both enables are high the op is a read and the write is ignored.
  - ACCESS: each beat is held for WAIT_CYCLES clocks. On the last clock of a read beat, sram_dq_in is captured into the corresponding slice of the read buffer. After the last clock of beat BEATS-1, go to DONE.
  - DONE: ready=1 for exactly one cycle; on a read, read_data is updated from the buffer; then go to IDLE.
- freeze = (mem_r_en | mem_w_en) & (state != DONE). It is combinational, so it is high in the same cycle the request appears. The pipeline advances in the DONE cycle.
- Latency: request seen at cycle 0 gives ready at cycle 1 + BEATS*WAIT_CYCLES (cycle 5 with defaults).
- SRAM signals during ACCESS:
  - sram_ce_n=0.
  - Read: sram_oe_n=0, sram_dq_oe=0.
  - Write: sram_dq_oe=1 and sram_dq_out = the current slice. sram_we_n=0 on all clocks of the beat except the last; if WAIT_CYCLES=1, sram_we_n=0 for the whole beat.
- SRAM signals outside ACCESS: the reset values above, except sram_addr, which holds its last value.
- read_data holds its value between reads. A write does not change it.
- Back-to-back memory instructions: the next request is accepted in the IDLE cycle after DONE. freeze is low only in the DONE cycle.

Test Plan:
1. Hold rst=0 for 2 cycles with mem_r_en=1 -> ready=0, freeze=0 during reset, sram_ce_n=1, sram_we_n=1, read_data=0.
2. Store, defaults: mem_w_en=1, address=1032, write_data=0xDEADBEEF.
   - freeze=1 for cycles 0-4; ready pulse at cycle 5.
   - sram_addr=4 with sram_dq_out=0xBEEF, then sram_addr=5 with 0xDEAD.
   - sram_we_n=0 for exactly 1 clock per beat.
3. Load after step 2, with an SRAM model: mem_r_en=1, address=1032 -> read_data=0xDEADBEEF at cycle 5, freeze=0 at cycle 5, sram_dq_oe=0 throughout.
4. Load at 1032 immediately followed by a store at 1036 -> freeze low only at cycle 5; second access uses sram_addr=6,7; ready pulses at cycles 5 and 11.
5. rst=0 at cycle 2 of a store to 1032 -> at the next edge sram_we_n=1 and sram_ce_n=1; ready never pulses; SRAM model shows no write at word 5.
6. SRAM_DQ_W=32, WAIT_CYCLES=1: load at address=1028 -> single beat with sram_addr=1; ready at cycle 2; read_data equals the model word.

Source files
------------

// File: rtl/mem_sram_ctrl.sv
// Memory-stage controller: turns a single-cycle load/store into a multi-beat,
// multi-cycle external SRAM access and holds the pipeline until it completes.
module mem_sram_ctrl #(
    parameter int DATA_W      = 32,
    parameter int SRAM_DQ_W   = 16,
    parameter int SRAM_ADDR_W = 18,
    parameter int WAIT_CYCLES = 2,
    parameter int BASE_ADDR   = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mem_r_en,
    input  logic                   mem_w_en,
    input  logic [DATA_W-1:0]      address,
    input  logic [DATA_W-1:0]      write_data,
    output logic [DATA_W-1:0]      read_data,
    output logic                   ready,
    output logic                   freeze,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    input  logic [SRAM_DQ_W-1:0]   sram_dq_in,
    output logic [SRAM_DQ_W-1:0]   sram_dq_out,
    output logic                   sram_dq_oe,
    output logic                   sram_ce_n,
    output logic                   sram_oe_n,
    output logic                   sram_we_n
);

    localparam int BEATS   = DATA_W / SRAM_DQ_W;
    localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CYC_W   = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int BYTE_SH = $clog2(DATA_W / 8);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [CYC_W-1:0]  LAST_CYC  = CYC_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t                 state_q, state_d;
    logic [BEAT_W-1:0]      beat_q, beat_d;
    logic [CYC_W-1:0]       cyc_q, cyc_d;
    logic                   is_read_q, is_read_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic [DATA_W-1:0]      rd_buf_q, rd_buf_d;
    logic [DATA_W-1:0]      read_data_q, read_data_d;
    logic [SRAM_ADDR_W-1:0] sram_addr_q, sram_addr_d;

    logic [DATA_W-1:0]      word_addr;
    logic [DATA_W-1:0]      rd_merge;
    logic                   beat_end;
    logic                   in_access;

    always_comb begin
        word_addr = (address - DATA_W'(BASE_ADDR)) >> BYTE_SH;
        beat_end  = (cyc_q == LAST_CYC);
        rd_merge  = rd_buf_q;
        rd_merge[int'(beat_q) * SRAM_DQ_W +: SRAM_DQ_W] = sram_dq_in;

        state_d     = state_q;
        beat_d      = beat_q;
        cyc_d       = cyc_q;
        is_read_d   = is_read_q;
        wdata_d     = wdata_q;
        rd_buf_d    = rd_buf_q;
        read_data_d = read_data_q;
        sram_addr_d = sram_addr_q;

        case (state_q)
            IDLE: begin
                if (mem_r_en || mem_w_en) begin
                    state_d     = ACCESS;
                    is_read_d   = mem_r_en;
                    wdata_d     = write_data;
                    beat_d      = '0;
                    cyc_d       = '0;
                    sram_addr_d = SRAM_ADDR_W'(word_addr * DATA_W'(BEATS));
                end
            end
            ACCESS: begin
                if (beat_end) begin
                    cyc_d = '0;
                    if (is_read_q) rd_buf_d = rd_merge;
                    if (beat_q == LAST_BEAT) begin
                        state_d = DONE;
                        // Loaded into read_data on entry so it is valid during the DONE cycle.
                        if (is_read_q) read_data_d = rd_merge;
                    end else begin
                        beat_d      = beat_q + BEAT_W'(1);
                        sram_addr_d = sram_addr_q + SRAM_ADDR_W'(1);
                    end
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            cyc_q       <= '0;
            is_read_q   <= 1'b0;
            wdata_q     <= '0;
            rd_buf_q    <= '0;
            read_data_q <= '0;
            sram_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            cyc_q       <= cyc_d;
            is_read_q   <= is_read_d;
            wdata_q     <= wdata_d;
            rd_buf_q    <= rd_buf_d;
            read_data_q <= read_data_d;
            sram_addr_q <= sram_addr_d;
        end
    end

    // Strobes decode straight from the state so a reset releases the SRAM at once.
    always_comb begin
        in_access   = (state_q == ACCESS);
        ready       = (state_q == DONE);
        freeze      = rst && (mem_r_en || mem_w_en) && (state_q != DONE);
        sram_ce_n   = !in_access;
        sram_oe_n   = !(in_access && is_read_q);
        sram_dq_oe  = in_access && !is_read_q;
        sram_dq_out = '0;
        if (sram_dq_oe) sram_dq_out = wdata_q[int'(beat_q) * SRAM_DQ_W +: SRAM_DQ_W];
        sram_we_n   = !(sram_dq_oe && ((WAIT_CYCLES == 1) || !beat_end));
    end

    assign read_data = read_data_q;
    assign sram_addr = sram_addr_q;

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Bench for mem_sram_ctrl: directed table, reset abort, random ops against a
// word-level reference memory, and a single-beat configuration.
module tb_mem_sram_ctrl;
    localparam int W = 2;
    localparam int B = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_r_en, mem_w_en;
    logic [31:0] address, write_data, read_data;
    logic        ready, freeze;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_in, sram_dq_out;
    logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;

    logic        r2, w2;
    logic [31:0] addr2, wd2, rdata2;
    logic        ready2, freeze2;
    logic [17:0] saddr2;
    logic [31:0] dq_in2, dq_out2;
    logic        dq_oe2, ce_n2, oe_n2, we_n2;

    int          n_pass = 0;
    int          n_total = 0;
    int          cyc_cnt = 0;
    logic [31:0] exp_rd_g;
    logic [31:0] ref_mem [64];
    logic [15:0] mem1 [256];
    logic [31:0] mem2 [16];
    bit          mem_load;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
    } vec_t;
    vec_t vt [7];

    mem_sram_ctrl dut (
        .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .address(address), .write_data(write_data), .read_data(read_data),
        .ready(ready), .freeze(freeze), .sram_addr(sram_addr),
        .sram_dq_in(sram_dq_in), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
    );

    mem_sram_ctrl #(.SRAM_DQ_W(32), .WAIT_CYCLES(1)) dut2 (
        .clk(clk), .rst(rst), .mem_r_en(r2), .mem_w_en(w2),
        .address(addr2), .write_data(wd2), .read_data(rdata2),
        .ready(ready2), .freeze(freeze2), .sram_addr(saddr2),
        .sram_dq_in(dq_in2), .sram_dq_out(dq_out2), .sram_dq_oe(dq_oe2),
        .sram_ce_n(ce_n2), .sram_oe_n(oe_n2), .sram_we_n(we_n2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic logic [15:0] f1(input int i);
        return 16'(i * 40503 + 4660);
    endfunction

    function automatic logic [31:0] f2(input int i);
        return 32'(i) * 32'h9E3779B1 + 32'h55;
    endfunction

    // SRAM models: write on any clock with CE and WE asserted, asynchronous read.
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 256; i++) mem1[i] <= f1(i);
            for (int i = 0; i < 16; i++) mem2[i] <= f2(i);
        end else begin
            if (!sram_ce_n && !sram_we_n) mem1[sram_addr[7:0]] <= sram_dq_out;
            if (!ce_n2 && !we_n2) mem2[saddr2[3:0]] <= dq_out2;
        end
    end
    assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? mem1[sram_addr[7:0]] : 16'h0;
    assign dq_in2     = (!ce_n2 && !oe_n2) ? mem2[saddr2[3:0]] : 32'h0;

    initial begin
        mem_load = 1'b1;
        @(posedge clk);
        #1 mem_load = 1'b0;
    end

    task automatic check(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic run_op(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_rd, output int rdy_cyc);
        int          lat, k, beat, pos;
        bit          frz_ok, seq_ok;
        logic [17:0] base;
        base = 18'(((a - 32'd1024) >> 2) * B);
        mem_r_en = rd; mem_w_en = wr; address = a; write_data = wd;
        lat = -1; k = 0; frz_ok = 1'b1; seq_ok = 1'b1; rdy_cyc = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (ready) begin
                lat = c;
                rdy_cyc = cyc_cnt;
                break;
            end
            if (!freeze) frz_ok = 1'b0;
            if (!sram_ce_n) begin
                beat = k / W;
                pos  = k % W;
                if (sram_addr != base + 18'(beat)) seq_ok = 1'b0;
                if (rd) begin
                    if (sram_oe_n || sram_dq_oe || !sram_we_n) seq_ok = 1'b0;
                end else if (!sram_dq_oe || sram_dq_out != 16'(wd >> (16 * beat))
                             || sram_we_n != (pos == W - 1)) begin
                    seq_ok = 1'b0;
                end
                k++;
            end
            @(posedge clk); #1;
        end
        check(lat == 1 + B * W, "latency", lat, 1 + B * W);
        check(frz_ok && !freeze, "freeze", {31'd0, freeze}, 0);
        check(seq_ok && k == B * W, "sram_seq", k, B * W);
        check(read_data === exp_rd, "read_data", read_data, exp_rd);
        if (wr && !rd) ref_mem[int'((a - 32'd1024) >> 2)] = wd;
        if (rd) exp_rd_g = exp_rd;
        $display("op rd=%0b wr=%0b addr=%0d wdata=%h lat=%0d read_data=%h", rd, wr, a, wd, lat, read_data);
        @(posedge clk); #1;
        mem_r_en = 1'b0; mem_w_en = 1'b0;
    endtask

    task automatic run2(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd);
        int lat, k;
        bit ok;
        r2 = rd; w2 = wr; addr2 = a; wd2 = wd;
        lat = -1; k = 0; ok = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (ready2) begin
                lat = c;
                break;
            end
            if (!freeze2) ok = 1'b0;
            if (!ce_n2) begin
                k++;
                if (saddr2 != 18'((a - 32'd1024) >> 2)) ok = 1'b0;
                if (wr && (we_n2 || !dq_oe2 || dq_out2 != wd)) ok = 1'b0;
                if (rd && (oe_n2 || dq_oe2)) ok = 1'b0;
            end
            @(posedge clk); #1;
        end
        check(lat == 2, "w1_latency", lat, 2);
        check(ok && k == 1, "w1_seq", k, 1);
        check(rdata2 === exp_rd, "w1_read_data", rdata2, exp_rd);
        $display("op32 rd=%0b wr=%0b addr=%0d wdata=%h lat=%0d read_data=%h", rd, wr, a, wd, lat, rdata2);
        @(posedge clk); #1;
        r2 = 1'b0; w2 = 1'b0;
    endtask

    initial begin
        int          rc, prev, w;
        bit          rd, wr, rdy_seen;
        logic [31:0] a, wd, exp;

        for (int i = 0; i < 64; i++) ref_mem[i] = {f1(2 * i + 1), f1(2 * i)};
        exp_rd_g = 32'h0;
        vt[0] = '{1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 32'h0};
        vt[1] = '{1'b1, 1'b0, 32'd1032, 32'h0,        32'hDEADBEEF};
        vt[2] = '{1'b0, 1'b1, 32'd1036, 32'h12345678, 32'hDEADBEEF};
        vt[3] = '{1'b1, 1'b0, 32'd1036, 32'h0,        32'h12345678};
        vt[4] = '{1'b1, 1'b1, 32'd1040, 32'hFFFF0000, {f1(9), f1(8)}};
        vt[5] = '{1'b1, 1'b0, 32'd1040, 32'h0,        {f1(9), f1(8)}};
        vt[6] = '{1'b1, 1'b0, 32'd1032, 32'h0,        32'hDEADBEEF};

        rst = 1'b0; mem_r_en = 1'b1; mem_w_en = 1'b0; address = 32'd1032; write_data = 32'h0;
        r2 = 1'b0; w2 = 1'b0; addr2 = 32'h0; wd2 = 32'h0;
        repeat (2) begin
            @(negedge clk);
            check(!ready, "rst_ready", {31'd0, ready}, 0);
            check(!freeze, "rst_freeze", {31'd0, freeze}, 0);
            check(sram_ce_n && sram_we_n && sram_oe_n && !sram_dq_oe, "rst_strobes",
                  {28'd0, sram_ce_n, sram_we_n, sram_oe_n, sram_dq_oe}, 32'he);
            check(read_data === 32'h0, "rst_read_data", read_data, 0);
            check(sram_addr === 18'h0 && sram_dq_out === 16'h0, "rst_addr_dq", {14'd0, sram_addr}, 0);
        end
        @(posedge clk); #1;
        rst = 1'b1; mem_r_en = 1'b0;

        // Directed table, every entry issued back to back
        prev = 0;
        for (int i = 0; i < 7; i++) begin
            run_op(vt[i].rd, vt[i].wr, vt[i].addr, vt[i].wd, vt[i].exp_rd, rc);
            if (i > 0) check(rc - prev == 2 + B * W, "b2b_gap", rc - prev, 2 + B * W);
            prev = rc;
        end

        // Reset in cycle 2 of a store: beat 0 already written, beat 1 never starts
        mem_w_en = 1'b1; address = 32'd1032; write_data = 32'hCAFEF00D;
        rdy_seen = 1'b0;
        repeat (2) begin
            @(negedge clk); rdy_seen |= ready;
            @(posedge clk); #1;
        end
        rst = 1'b0;
        @(negedge clk); rdy_seen |= ready;
        @(posedge clk); #1;
        mem_w_en = 1'b0;
        @(negedge clk);
        check(sram_we_n && sram_ce_n, "abort_release", {30'd0, sram_we_n, sram_ce_n}, 3);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (8) begin
            @(negedge clk); rdy_seen |= ready;
            @(posedge clk); #1;
        end
        check(!rdy_seen, "abort_no_ready", {31'd0, rdy_seen}, 0);
        check(mem1[5] === 16'hDEAD, "abort_word5", {16'd0, mem1[5]}, 32'hDEAD);
        check(mem1[4] === 16'hF00D, "abort_word4", {16'd0, mem1[4]}, 32'hF00D);
        check(read_data === 32'h0, "abort_read_data", read_data, 0);
        $display("abort store addr=1032 ready_seen=%0b sram4=%h sram5=%h", rdy_seen, mem1[4], mem1[5]);
        ref_mem[2][15:0] = 16'hF00D;
        exp_rd_g = 32'h0;

        // Random loads/stores against the word-level reference memory
        for (int n = 0; n < 40; n++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                check(!freeze && !ready, "idle", {30'd0, freeze, ready}, 0);
                @(posedge clk); #1;
            end
            rd = 1'($urandom_range(0, 1));
            wr = !rd || ($urandom_range(0, 3) == 0);
            w  = int'($urandom_range(0, 63));
            a  = 32'd1024 + 32'(4 * w);
            wd = $urandom;
            exp = rd ? ref_mem[w] : exp_rd_g;
            run_op(rd, wr, a, wd, exp, rc);
        end

        // Single-beat, single-wait configuration
        run2(1'b1, 1'b0, 32'd1028, 32'h0, f2(1));
        run2(1'b0, 1'b1, 32'd1032, 32'h0BADF00D, f2(1));
        run2(1'b1, 1'b0, 32'd1032, 32'h0, 32'h0BADF00D);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
